// File: rtl/dtack_watchdog_pkg.sv
// dtack_watchdog_pkg: shared channel state encoding, default timing constants
// and effective-timeout selection for the multi-channel DTACK watchdog.
package dtack_watchdog_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE, TMO} state_t;

    localparam int DEFAULT_TIMEOUT = 200;
    localparam int PRESCALE        = 125;

    function automatic int eff_timeout(input int cfg, input int dflt);
        return (cfg == 0) ? dflt : cfg;
    endfunction

endpackage

// File: rtl/dtack_watchdog_chan.sv
// dtack_watchdog_chan: one access channel with its own prescaler, microsecond
// counter, latched timeout limit and timeout/elapsed-time status.
module dtack_watchdog_chan #(
    parameter int PRESCALE        = dtack_watchdog_pkg::PRESCALE,
    parameter int PRE_W           = 7,
    parameter int TMO_W           = 8,
    parameter int DEFAULT_TIMEOUT = dtack_watchdog_pkg::DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             done,
    input  logic [TMO_W-1:0] timeout_cfg,
    input  logic             err_clr,
    output logic             busy,
    output logic             tmo_active,
    output logic             tmo_pulse,
    output logic             tmo_sticky,
    output logic [TMO_W-1:0] last_time,
    output logic             last_valid
);
    import dtack_watchdog_pkg::*;

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [TMO_W-1:0]   us_q, us_d, tlim_q, tlim_d, last_time_q, last_time_d;
    logic               tmo_pulse_q, tmo_pulse_d, tmo_sticky_q, tmo_sticky_d;
    logic               last_valid_q, last_valid_d;
    logic               wrap, hit;

    assign wrap = pre_q == PRE_W'(PRESCALE - 1);
    assign hit  = wrap && (us_q == tlim_q - TMO_W'(1));

    always_comb begin
        state_d      = state_q;
        pre_d        = pre_q;
        us_d         = us_q;
        tlim_d       = tlim_q;
        tmo_pulse_d  = 1'b0;
        tmo_sticky_d = tmo_sticky_q & ~err_clr;
        last_time_d  = last_time_q;
        last_valid_d = last_valid_q;
        if (!start) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            state_d      = RUN;
            pre_d        = '0;
            us_d         = '0;
            tlim_d       = TMO_W'(eff_timeout(int'(timeout_cfg), DEFAULT_TIMEOUT));
            last_valid_d = 1'b0;
        end else if (state_q == RUN) begin
            // done outranks a timeout landing on the same edge
            if (done) begin
                state_d      = DONE;
                last_time_d  = us_q;
                last_valid_d = 1'b1;
            end else if (hit) begin
                state_d      = TMO;
                tmo_pulse_d  = 1'b1;
                tmo_sticky_d = 1'b1;
            end else begin
                pre_d = wrap ? '0 : pre_q + PRE_W'(1);
                us_d  = wrap ? us_q + TMO_W'(1) : us_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pre_q        <= '0;
            us_q         <= '0;
            tlim_q       <= '0;
            tmo_pulse_q  <= 1'b0;
            tmo_sticky_q <= 1'b0;
            last_time_q  <= '0;
            last_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            us_q         <= us_d;
            tlim_q       <= tlim_d;
            tmo_pulse_q  <= tmo_pulse_d;
            tmo_sticky_q <= tmo_sticky_d;
            last_time_q  <= last_time_d;
            last_valid_q <= last_valid_d;
        end
    end

    assign busy       = state_q == RUN;
    assign tmo_active = state_q == TMO;
    assign tmo_pulse  = tmo_pulse_q;
    assign tmo_sticky = tmo_sticky_q;
    assign last_time  = last_time_q;
    assign last_valid = last_valid_q;

endmodule

// File: rtl/dtack_watchdog_mc.sv
// dtack_watchdog_mc: NCH independent VME access watchdog channels sharing a
// runtime timeout setting, each with exact per-channel timing.
module dtack_watchdog_mc #(
    parameter int NCH             = 4,
    parameter int PRESCALE        = dtack_watchdog_pkg::PRESCALE,
    parameter int PRE_W           = 7,
    parameter int TMO_W           = 8,
    parameter int DEFAULT_TIMEOUT = dtack_watchdog_pkg::DEFAULT_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       start,
    input  logic [NCH-1:0]       done,
    input  logic [TMO_W-1:0]     timeout_cfg,
    input  logic [NCH-1:0]       err_clr,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       tmo_active,
    output logic [NCH-1:0]       tmo_pulse,
    output logic [NCH-1:0]       tmo_sticky,
    output logic [NCH*TMO_W-1:0] last_time,
    output logic [NCH-1:0]       last_valid
);
    import dtack_watchdog_pkg::*;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        dtack_watchdog_chan #(
            .PRESCALE(PRESCALE),
            .PRE_W(PRE_W),
            .TMO_W(TMO_W),
            .DEFAULT_TIMEOUT(DEFAULT_TIMEOUT)
        ) u_chan (
            .clk(clk),
            .reset(reset),
            .start(start[i]),
            .done(done[i]),
            .timeout_cfg(timeout_cfg),
            .err_clr(err_clr[i]),
            .busy(busy[i]),
            .tmo_active(tmo_active[i]),
            .tmo_pulse(tmo_pulse[i]),
            .tmo_sticky(tmo_sticky[i]),
            .last_time(last_time[i*TMO_W +: TMO_W]),
            .last_valid(last_valid[i])
        );
    end

endmodule

// File: doc/dtack_watchdog_mc.md
Name: dtack_watchdog_mc

Overview:
- Multi-channel VME access watchdog. It is the parametrised successor to the single-channel fixed 200 us DTACK timeout.
- Each channel times one bus-access window in microsecond units and flags a timeout.
- Each channel also captures the elapsed time of accesses that complete normally.
- Sits between the VME slave/master sequencers (which drive start/done) and the CSR block (which programs the timeout and reads the status).

Parameters:
- NCH, 4, number of independent access channels.
- PRESCALE, 125, clk cycles per microsecond tick (8 ns clk gives 1 us).
- PRE_W, 7, prescaler counter width; must satisfy 2^PRE_W >= PRESCALE.
- TMO_W, 8, width of timeout and elapsed-time fields in microseconds.
- DEFAULT_TIMEOUT, 200, timeout in microseconds used when timeout_cfg is 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  NCH  per channel, level: high = access in progress; low aborts/idles the channel.
- done  in  NCH  per channel: access terminated normally (DTACK/BERR seen); sampled only while running.
- timeout_cfg  in  TMO_W  runtime timeout in us; 0 selects DEFAULT_TIMEOUT; latched per channel at run entry.
- err_clr  in  NCH  per channel: clears tmo_sticky.
- busy  out  NCH  channel in RUN state.
- tmo_active  out  NCH  level timeout flag; cleared when start goes low.
- tmo_pulse  out  NCH  one-cycle strobe on the edge tmo_active sets.
- tmo_sticky  out  NCH  latched timeout status until err_clr.
- last_time  out  NCH*TMO_W  per channel: completed microseconds at the last done; channel i occupies bits [i*TMO_W +: TMO_W].
- last_valid  out  NCH  last_time updated since the previous run entry.

Behaviour:
- Reset (asynchronous, any state, mid-access included): all outputs 0, all counters 0, all channels IDLE.
- Per-channel FSM, states IDLE, RUN, DONE, TMO; all registered.
- IDLE -> RUN: on the edge that samples start=1. Load pre=0, us=0; latch tlim = timeout_cfg, or DEFAULT_TIMEOUT if timeout_cfg==0; clear last_valid.
- RUN counting, each edge:
  - pre increments.
  - When pre==PRESCALE-1: pre wraps to 0 and us increments.
- RUN -> TMO: at the edge where pre==PRESCALE-1 and us==tlim-1.
  - tmo_active=1, tmo_sticky=1, tmo_pulse=1 for exactly one cycle.
  - tmo_active is therefore visible exactly PRESCALE*tlim cycles after the run-entry edge.
- RUN -> DONE: on the edge sampling done=1.
  - last_time = us (completed microseconds, truncated); last_valid=1.
- Simultaneous done and timeout on the same edge: done wins. Go to DONE; no timeout flags.
- DONE and TMO hold (counters frozen) while start=1. done is ignored in these states.
- start=0 in any state: next edge -> IDLE, busy=0, tmo_active=0. tmo_sticky, last_time and last_valid are unaffected.
- Back-to-back access: start must be low for at least one edge to re-arm. Continuous start never restarts timing.
- err_clr and a timeout set on the same edge: set wins (tmo_sticky stays 1).
- timeout_cfg changes during RUN have no effect until the next run entry.
- Channels are fully independent; there is no shared prescaler, so every channel has exact timing.

Decomposition:
- Package dtack_watchdog_pkg holds:
  - the state typedef (IDLE, RUN, DONE, TMO);
  - the default constants DEFAULT_TIMEOUT and PRESCALE;
  - a function selecting the effective timeout (0 -> default).
- Sub-module dtack_watchdog_chan implements one channel (FSM, pre/us counters, tlim latch, status). It is instantiated NCH times by a generate loop in the top.

Test Plan (all scenarios use PRESCALE=4, PRE_W=2, TMO_W=8, DEFAULT_TIMEOUT=5, NCH=2):
- Default timeout: timeout_cfg=0; raise start[0] and sample it at edge 0 -> tmo_active[0] and tmo_pulse[0] rise after edge 20; tmo_pulse is low after edge 21; tmo_sticky[0]=1.
- Programmed timeout with normal completion: timeout_cfg=3; start[1] sampled at edge 0; done[1] at edge 9 -> busy drops, last_time[1]=2, last_valid[1]=1, no timeout at edge 12.
- Race: timeout_cfg=2; done[0] asserted exactly at edge 8 (the timeout edge) -> DONE, last_time=1, tmo_active/tmo_sticky stay 0.
- Abort and sticky: after a timeout on ch0, drop start at edge 25 -> tmo_active[0]=0 after edge 25, tmo_sticky[0] still 1; pulse err_clr[0] -> tmo_sticky[0]=0. Assert err_clr on the timeout edge -> tmo_sticky=1.
- Reset mid-run: assert reset asynchronously at edge 10 of a run (between edges) -> all outputs 0 immediately; after release with start still high, a new run begins at the first sampling edge and times out 20 cycles later.
- Independence: stagger channels by 3 cycles with different timeout_cfg values latched -> each times out at its own entry+4*tlim; a mid-run cfg change has no effect.
